// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared widths, FIFO entry type and helpers for the writeback arbiter
//
// Holds the register-file geometry used across the writeback slice:
//   REGISTER_ADDR_WIDTH / REGISTER_WIDTH : register file address and data widths
//   WB_LU_DEPTH_DEFAULT                  : default long-unit result FIFO depth
//   wb_entry_t                           : one queued long-unit result
//   wb_src_e                             : which source owns the write port this cycle
//   addr_hit()                           : in-flight write matches a read address
package writeback_arbiter_pkg;

    localparam int REGISTER_ADDR_WIDTH = 5;
    localparam int REGISTER_WIDTH      = 32;
    localparam int NUM_REGISTERS       = 1 << REGISTER_ADDR_WIDTH;
    localparam int WB_LU_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [REGISTER_ADDR_WIDTH-1:0] address;
        logic [REGISTER_WIDTH-1:0]      data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_SRC_IDLE = 2'd0,
        WB_SRC_PIPE = 2'd1,
        WB_SRC_LU   = 2'd2
    } wb_src_e;

    // Register 0 is hardwired, so a write to it can never be a hazard.
    function automatic logic addr_hit(
        input logic                           valid,
        input logic [REGISTER_ADDR_WIDTH-1:0] w_addr,
        input logic [REGISTER_ADDR_WIDTH-1:0] r_addr
    );
        return valid && (w_addr != '0) && (w_addr == r_addr);
    endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// rtl/writeback_arbiter_fifo.sv - synchronous FIFO buffering long-unit results
//
// Module wb_fifo. Parameters WIDTH (entry width) and DEPTH (power of two, >=2).
// Ports:
//   clk, reset (sync, active-high), clk_enable (freezes all state when low)
//   push, push_data  : write an entry (ignored when full)
//   pop, pop_data    : remove the head entry (ignored when empty); pop_data is the
//                      head, valid combinationally whenever !empty
//   full, empty      : occupancy flags
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates the full and empty cases when indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clk_enable) begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (clk_enable && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipeline and long-unit results onto the register-file write port
//
// Optional feature macro: WB_BYPASS_EN (adds forwarding outputs, drops in-flight hazard from stall).
// Ports:
//   clk, reset (sync, active-high), clk_enable (freezes all state when low)
//   pipe_valid/pipe_address/pipe_data : single-cycle result, always wins the port
//   issue_valid/issue_address         : long-latency op issued, marks destination pending
//   lu_valid/lu_ready/lu_address/lu_data : long-unit result handshake into the FIFO
//   r_address1/r_address2             : decode-stage read addresses
//   stall                             : read hazard for decode
//   w_address/w_data/w_enable         : registered register-file write port
//   error                             : sticky protocol violation
//   fwd1_valid/fwd2_valid/fwd_data    : forwarding of the in-flight write (WB_BYPASS_EN only)
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int LU_DEPTH = WB_LU_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clk_enable,
    input  logic                           pipe_valid,
    input  logic [REGISTER_ADDR_WIDTH-1:0] pipe_address,
    input  logic [REGISTER_WIDTH-1:0]      pipe_data,
    input  logic                           issue_valid,
    input  logic [REGISTER_ADDR_WIDTH-1:0] issue_address,
    input  logic                           lu_valid,
    output logic                           lu_ready,
    input  logic [REGISTER_ADDR_WIDTH-1:0] lu_address,
    input  logic [REGISTER_WIDTH-1:0]      lu_data,
    input  logic [REGISTER_ADDR_WIDTH-1:0] r_address1,
    input  logic [REGISTER_ADDR_WIDTH-1:0] r_address2,
    output logic                           stall,
`ifdef WB_BYPASS_EN
    output logic                           fwd1_valid,
    output logic                           fwd2_valid,
    output logic [REGISTER_WIDTH-1:0]      fwd_data,
`endif
    output logic [REGISTER_ADDR_WIDTH-1:0] w_address,
    output logic [REGISTER_WIDTH-1:0]      w_data,
    output logic                           w_enable,
    output logic                           error
);

    wb_entry_t                head;
    wb_entry_t                lu_entry;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     lu_push;
    wb_src_e                  src;
    logic [NUM_REGISTERS-1:0] pending;
    logic [NUM_REGISTERS-1:0] pending_next;
    logic                     err_event;
    logic                     hit1;
    logic                     hit2;
    logic                     pending_hit;

    assign lu_entry = '{address: lu_address, data: lu_data};
    // Ready uses the pre-pop full state; a same-cycle pop does not open a slot early.
    assign lu_ready = !fifo_full && !reset;
    assign lu_push  = lu_valid && lu_ready;

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (LU_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .push       (lu_push),
        .push_data  (lu_entry),
        .pop        (src == WB_SRC_LU),
        .pop_data   (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        src = WB_SRC_IDLE;
        if (pipe_valid)       src = WB_SRC_PIPE;
        else if (!fifo_empty) src = WB_SRC_LU;
    end

    // Clear for the popped entry first so that a same-cycle re-issue keeps the bit set.
    always_comb begin
        pending_next = pending;
        if (src == WB_SRC_LU) pending_next[head.address] = 1'b0;
        if (issue_valid && (issue_address != '0)) pending_next[issue_address] = 1'b1;
        pending_next[0] = 1'b0;
    end

    assign err_event = (issue_valid && pending[issue_address])
                     | (pipe_valid && (pipe_address != '0) && pending[pipe_address])
                     | (lu_valid && !pending[lu_address]);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            error     <= 1'b0;
            w_enable  <= 1'b0;
            w_address <= '0;
            w_data    <= '0;
        end else if (clk_enable) begin
            pending <= pending_next;
            error   <= error | err_event;
            case (src)
                WB_SRC_PIPE: begin
                    w_enable  <= (pipe_address != '0);
                    w_address <= pipe_address;
                    w_data    <= pipe_data;
                end
                WB_SRC_LU: begin
                    w_enable  <= (head.address != '0);
                    w_address <= head.address;
                    w_data    <= head.data;
                end
                default: w_enable <= 1'b0;
            endcase
        end
    end

    assign hit1        = addr_hit(w_enable, w_address, r_address1);
    assign hit2        = addr_hit(w_enable, w_address, r_address2);
    assign pending_hit = pending[r_address1] | pending[r_address2];

`ifdef WB_BYPASS_EN
    assign fwd1_valid = hit1;
    assign fwd2_valid = hit2;
    assign fwd_data   = w_data;
    assign stall      = pending_hit;
`else
    // The in-flight write keeps stall high for the cycle the file is being written.
    assign stall      = pending_hit | hit1 | hit2;
`endif

endmodule
